// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_ctrl
// Brief    : Bit-serial A - B - bin using one full-subtractor cell, LSB first,
//            with valid/ready handshakes on operands and result.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_d;
    logic               w_bout;
    logic               w_last;

    // The single subtractor cell, fed by the operand LSBs and the borrow chain.
    assign w_d    = r_m[0] ^ r_s[0] ^ r_borrow;
    assign w_bout = (~r_m[0] & (r_s[0] | r_borrow)) | (r_s[0] & r_borrow);
    assign w_last = (r_cnt == c_LAST);

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_next_state = c_RUN;
            c_RUN:   if (w_last)    w_next_state = c_DONE;
            c_DONE:  if (out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        busy      = (r_state == c_RUN) || (r_state == c_DONE);
    end

    // diff/borrow_out are only written on the final RUN edge, so they hold
    // the last result through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            r_m        <= '0;
            r_s        <= '0;
            r_res      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_m      <= minuend;
                        r_s      <= subtrahend;
                        r_borrow <= borrow_in;
                        r_cnt    <= '0;
                    end
                end
                c_RUN: begin
                    r_m      <= r_m >> 1;
                    r_s      <= r_s >> 1;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        diff       <= w_res_next;
                        borrow_out <= w_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor_ctrl
// Brief    : Directed plus random checks of the serial subtractor at WIDTH
//            8, 1 and 16 against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv8, ir8, bin8, ov8, or8, bo8, busy8;
    logic [7:0]  a8, b8, d8;
    logic        iv1, ir1, bin1, ov1, or1, bo1, busy1;
    logic [0:0]  a1, b1, d1;
    logic        iv16, ir16, bin16, ov16, or16, bo16, busy16;
    logic [15:0] a16, b16, d16;

    int vectors = 0;
    int fails   = 0;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .minuend(a8), .subtrahend(b8), .borrow_in(bin8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8),
        .busy(busy8)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .minuend(a1), .subtrahend(b1), .borrow_in(bin1),
        .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow_out(bo1),
        .busy(busy1)
    );

    serial_subtractor_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .minuend(a16), .subtrahend(b16), .borrow_in(bin16),
        .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow_out(bo16),
        .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction reduced modulo 2^w.
    function automatic void model(input int w, input longint a, input longint b,
                                  input longint bin, output longint d, output logic bo);
        longint r;
        r  = a - b - bin;
        bo = (r < 0);
        d  = r & ((longint'(1) << w) - 1);
    endfunction

    task automatic op8(input int a, input int b, input int bin, input int hold);
        longint ed;
        logic   eb;
        model(8, a, b, bin, ed, eb);
        iv8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bin);
        or8 = (hold == 0);
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("w8_busy_after_accept", 32'(busy8), 32'd1);
        repeat (7) @(posedge clk);
        #1;
        check("w8_valid_early", 32'(ov8), 32'd0);
        @(posedge clk); #1;
        check("w8_valid", 32'(ov8), 32'd1);
        check("w8_diff", 32'(d8), 32'(ed));
        check("w8_borrow", 32'(bo8), 32'(eb));
        check("w8_in_ready_done", 32'(ir8), 32'd0);
        for (int i = 0; i < hold; i++) begin
            iv8 = 1'b1; a8 = 8'd1; b8 = 8'd0; bin8 = 1'b0;
            @(posedge clk); #1;
            check("w8_hold_valid", 32'(ov8), 32'd1);
            check("w8_hold_diff", 32'(d8), 32'(ed));
            check("w8_hold_borrow", 32'(bo8), 32'(eb));
            check("w8_hold_in_ready", 32'(ir8), 32'd0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        check("w8_valid_cleared", 32'(ov8), 32'd0);
        check("w8_in_ready_back", 32'(ir8), 32'd1);
        check("w8_diff_kept", 32'(d8), 32'(ed));
    endtask

    task automatic op1(input int a, input int b, input int bin);
        longint ed;
        logic   eb;
        model(1, a, b, bin, ed, eb);
        iv1 = 1'b1; a1 = 1'(a); b1 = 1'(b); bin1 = 1'(bin);
        @(posedge clk); #1;
        iv1 = 1'b0;
        check("w1_run_not_valid", 32'(ov1), 32'd0);
        @(posedge clk); #1;
        check("w1_valid", 32'(ov1), 32'd1);
        check("w1_diff", 32'(d1), 32'(ed));
        check("w1_borrow", 32'(bo1), 32'(eb));
        @(posedge clk); #1;
        check("w1_in_ready", 32'(ir1), 32'd1);
    endtask

    task automatic op16(input int a, input int b, input int bin);
        longint ed;
        logic   eb;
        model(16, a, b, bin, ed, eb);
        iv16 = 1'b1; a16 = 16'(a); b16 = 16'(b); bin16 = 1'(bin);
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("w16_valid_early", 32'(ov16), 32'd0);
        @(posedge clk); #1;
        check("w16_valid", 32'(ov16), 32'd1);
        check("w16_diff", 32'(d16), 32'(ed));
        check("w16_borrow", 32'(bo16), 32'(eb));
        @(posedge clk); #1;
        check("w16_in_ready", 32'(ir16), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; bin8 = 0; or8 = 1;
        iv1 = 0; a1 = 0; b1 = 0; bin1 = 0; or1 = 1;
        iv16 = 0; a16 = 0; b16 = 0; bin16 = 0; or16 = 1;
        #12;
        check("rst_in_ready", 32'(ir8), 32'd1);
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_diff", 32'(d8), 32'd0);
        check("rst_borrow", 32'(bo8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        op8(100, 37, 0, 0);
        op8(5, 10, 0, 0);
        op8(0, 0, 1, 0);
        op8(255, 255, 0, 0);
        op8(0, 255, 1, 0);
        op8(50, 20, 1, 5);

        // Abort an operation after three bits have been processed.
        iv8 = 1'b1; a8 = 8'd200; b8 = 8'd3; bin8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(ov8), 32'd0);
        check("abort_diff", 32'(d8), 32'd0);
        check("abort_borrow", 32'(bo8), 32'd0);
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_in_ready", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        op8(9, 4, 0, 0);

        for (int v = 0; v < 8; v++) begin
            op1((v >> 2) & 1, (v >> 1) & 1, v & 1);
        end

        for (int n = 0; n < 20; n++) begin
            op16(int'($urandom & 32'hFFFF), int'($urandom & 32'hFFFF),
                 int'($urandom & 32'h1));
        end
        op16(0, 16'hFFFF, 1);
        op16(16'hFFFF, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
